// File: rtl/wb_port_arbiter.sv
// Round-robin write-back arbiter for the register set's single write port,
// with a pending-write scoreboard feeding decode-stage operand stalls.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [ADDR_W-1:0] req2_rd,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [DATA_W-1:0] req2_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  localparam int NREG = 1 << ADDR_W;

  logic [1:0]        rr_ptr;
  logic [1:0]        ptr;
  logic [1:0]        gidx;
  logic [1:0]        ptr_nxt;
  logic              hit;
  logic              xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pend_nxt;

  // An illegal pointer value of 3 behaves as 0.
  assign ptr = (rr_ptr == 2'd3) ? 2'd0 : rr_ptr;
  assign hit = |req_valid;

  always_comb begin
    gidx = 2'd0;
    case (ptr)
      2'd1: begin
        if (req_valid[1])      gidx = 2'd1;
        else if (req_valid[2]) gidx = 2'd2;
        else                   gidx = 2'd0;
      end
      2'd2: begin
        if (req_valid[2])      gidx = 2'd2;
        else if (req_valid[0]) gidx = 2'd0;
        else                   gidx = 2'd1;
      end
      default: begin
        if (req_valid[0])      gidx = 2'd0;
        else if (req_valid[1]) gidx = 2'd1;
        else                   gidx = 2'd2;
      end
    endcase
  end

  assign req_ready = (rst_n && hit) ? (3'b001 << gidx) : 3'b000;
  assign xfer      = |(req_valid & req_ready);
  assign ptr_nxt   = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;

  always_comb begin
    sel_rd   = req0_rd;
    sel_data = req0_data;
    case (gidx)
      2'd1: begin
        sel_rd   = req1_rd;
        sel_data = req1_data;
      end
      2'd2: begin
        sel_rd   = req2_rd;
        sel_data = req2_data;
      end
      default: begin
        sel_rd   = req0_rd;
        sel_data = req0_data;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd0;
      we     <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
    end else begin
      we <= 1'b0;
      if (xfer) begin
        rr_ptr <= ptr_nxt;
        we     <= (sel_rd != '0);
        waddr  <= sel_rd;
        wdata  <= sel_data;
      end
    end
  end

  // Issue applied after clear: a new writer to the same register wins.
  always_comb begin
    pend_nxt = pending;
    if (xfer)
      pend_nxt[sel_rd] = 1'b0;
    if (issue_valid)
      pend_nxt[issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pending <= '0;
    else
      pending <= pend_nxt;
  end

  assign rs1_busy = pending[rs1_addr] & (rs1_addr != '0);
  assign rs2_busy = pending[rs2_addr] & (rs2_addr != '0);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized checks of wb_port_arbiter against a
// round-robin / scoreboard reference model.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [4:0]  rd0, rd1, rd2;
  logic [31:0] d0, d1, d2;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int vectors = 0;
  int miscompares = 0;

  int          m_ptr;
  bit [31:0]   m_pend;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_g;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_rd(rd0), .req1_rd(rd1), .req2_rd(rd2),
    .req0_data(d0), .req1_data(d1), .req2_data(d2),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++)
      if (v[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  function automatic logic [4:0] rd_of(input int s);
    return (s == 0) ? rd0 : (s == 1) ? rd1 : rd2;
  endfunction

  function automatic logic [31:0] data_of(input int s);
    return (s == 0) ? d0 : (s == 1) ? d1 : d2;
  endfunction

  function automatic bit busy_of(input logic [4:0] a);
    return (a != 0) && m_pend[a];
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_pend = '0; m_we = 0; m_waddr = '0; m_wdata = '0;
    m_g = -1;
  endtask

  // One clock: check at the falling edge, advance the model, then
  // return just after the rising edge so new inputs can be driven.
  task automatic cycle();
    logic [4:0] r;
    @(negedge clk);
    m_g = pick(req_valid, m_ptr);
    chk("ready", {29'd0, req_ready},
        (m_g < 0) ? 32'd0 : (32'd1 << m_g));
    chk("we", {31'd0, we}, {31'd0, m_we});
    chk("waddr", {27'd0, waddr}, {27'd0, m_waddr});
    chk("wdata", wdata, m_wdata);
    chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, busy_of(rs1_addr)});
    chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, busy_of(rs2_addr)});
    if (m_g >= 0) begin
      r = rd_of(m_g);
      m_ptr = (m_g + 1) % 3;
      m_we = (r != 0);
      m_waddr = r;
      m_wdata = data_of(m_g);
      m_pend[r] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (issue_valid) m_pend[issue_rd] = 1'b1;
    m_pend[0] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_ready", {29'd0, req_ready}, 32'd0);
    chk("rst_busy", {30'd0, rs1_busy, rs2_busy}, 32'd0);
    model_reset();
    req_valid = '0; issue_valid = 1'b0;
    repeat (2) @(posedge clk);
    chk("rst_waddr", {27'd0, waddr}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [2:0] sv;
    rst_n = 1'b1;
    req_valid = '0; rd0 = '0; rd1 = '0; rd2 = '0;
    d0 = '0; d1 = '0; d2 = '0;
    issue_valid = 1'b0; issue_rd = '0;
    rs1_addr = 5'd3; rs2_addr = 5'd4;
    model_reset();
    #2;
    do_reset();
    cycle();

    // single write from source 0
    req_valid = 3'b001; rd0 = 5'd5; d0 = 32'hDEADBEEF;
    #1 chk("single_ready", {29'd0, req_ready}, 32'd1);
    cycle();
    req_valid = '0;
    chk("single_we", {31'd0, we}, 32'd1);
    chk("single_waddr", {27'd0, waddr}, 32'd5);
    chk("single_wdata", wdata, 32'hDEADBEEF);
    cycle();
    chk("single_we_off", {31'd0, we}, 32'd0);

    // all three continuously valid: grants rotate 0,1,2
    do_reset();
    req_valid = 3'b111; rd0 = 5'd1; rd1 = 5'd2; rd2 = 5'd3;
    d0 = 32'h11; d1 = 32'h22; d2 = 32'h33;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_waddr", {27'd0, waddr}, (i % 3) + 1);
    end
    req_valid = '0;
    cycle();

    // scoreboard set then clear by source 1
    issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7;
    cycle();
    issue_valid = 1'b0;
    chk("sb_busy_set", {31'd0, rs1_busy}, 32'd1);
    req_valid = 3'b010; rd1 = 5'd7; d1 = 32'h7777;
    cycle();
    req_valid = '0;
    chk("sb_busy_clr", {31'd0, rs1_busy}, 32'd0);
    chk("sb_waddr", {27'd0, waddr}, 32'd7);
    cycle();

    // same-register set and clear: set wins
    issue_valid = 1'b1; issue_rd = 5'd9;
    cycle();
    req_valid = 3'b001; rd0 = 5'd9; rs2_addr = 5'd9;
    cycle();
    req_valid = '0; issue_valid = 1'b0;
    chk("collide_busy", {31'd0, rs2_busy}, 32'd1);
    cycle();

    // rd=0 from source 2: accepted but no write
    req_valid = 3'b100; rd2 = 5'd0; d2 = 32'hABCD;
    #1 chk("x0_ready", {29'd0, req_ready}, 32'd4);
    cycle();
    req_valid = '0;
    chk("x0_we", {31'd0, we}, 32'd0);
    issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0;
    cycle();
    issue_valid = 1'b0;
    cycle();
    chk("x0_busy", {31'd0, rs1_busy}, 32'd0);

    // reset in the cycle after a grant
    issue_valid = 1'b1; issue_rd = 5'd12; rs1_addr = 5'd12;
    req_valid = 3'b010; rd1 = 5'd20; d1 = 32'h5A5A5A5A;
    cycle();
    issue_valid = 1'b0;
    chk("mid_we_pre", {31'd0, we}, 32'd1);
    #2 do_reset();
    req_valid = 3'b111;
    cycle();
    chk("mid_ptr0", {27'd0, waddr}, {27'd0, rd0});
    req_valid = '0;
    cycle();

    // randomized traffic obeying the hold-until-ready rule
    sv = '0;
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < 3; s++) begin
        if (!sv[s] || m_g == s) begin
          sv[s] = ($urandom_range(0, 2) != 0);
          case (s)
            0: begin rd0 = 5'($urandom_range(0, 7)); d0 = $urandom; end
            1: begin rd1 = 5'($urandom_range(0, 7)); d1 = $urandom; end
            default: begin rd2 = 5'($urandom_range(0, 7)); d2 = $urandom; end
          endcase
        end
      end
      req_valid = sv;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd = 5'($urandom_range(0, 7));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      cycle();
      if (n == 200) begin
        #2 do_reset();
        sv = '0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
